// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: status codes and access FSM encoding shared by the register bus initiator and bridges.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'd0,
        RGGEN_EXOKAY       = 2'd1,
        RGGEN_SLAVE_ERROR  = 2'd2,
        RGGEN_DECODE_ERROR = 2'd3
    } rggen_status_e;

    typedef logic [1:0] rggen_access_state_t;

    localparam rggen_access_state_t STATE_IDLE     = 2'd0;
    localparam rggen_access_state_t STATE_ACCESS   = 2'd1;
    localparam rggen_access_state_t STATE_RESPONSE = 2'd2;

endpackage

// File: rtl/rggen_register_response_mux.sv
// rggen_register_response_mux: masked-OR of per-register status and read data over the hit registers.
module rggen_register_response_mux #(
    parameter int BUS_WIDTH = 32,
    parameter int REGISTERS = 1
) (
    input  logic [REGISTERS-1:0]           active,
    input  logic [REGISTERS-1:0]           ready,
    input  logic [2*REGISTERS-1:0]         status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] read_data,
    output logic                           any_active,
    output logic                           any_ready,
    output logic [1:0]                     hit_status,
    output logic [BUS_WIDTH-1:0]           hit_read_data
);
    logic [REGISTERS-1:0] hit;

    assign hit        = active & ready;
    assign any_active = |active;
    assign any_ready  = |hit;

    always_comb begin
        hit_status    = '0;
        hit_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            hit_status    = hit_status | (status[2*i+:2] & {2{hit[i]}});
            hit_read_data = hit_read_data | (read_data[BUS_WIDTH*i+:BUS_WIDTH] & {BUS_WIDTH{hit[i]}});
        end
    end
endmodule

// File: rtl/rggen_register_access_initiator.sv
// rggen_register_access_initiator: issues one host command at a time onto the register bus and
// returns a single registered response, handling decode errors and access timeouts.
module rggen_register_access_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_host_valid,
    output logic                           o_host_ready,
    input  logic                           i_host_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
    input  logic [BUS_WIDTH-1:0]           i_host_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_host_strobe,
    output logic                           o_host_resp_valid,
    input  logic                           i_host_resp_ready,
    output rggen_status_e                  o_host_status,
    output logic [BUS_WIDTH-1:0]           o_host_read_data,
    output logic                           o_reg_valid,
    output logic                           o_reg_write,
    output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
    output logic [BUS_WIDTH-1:0]           o_reg_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_reg_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);
    // A zero timeout still needs a 1-bit counter; it simply saturates and never fires.
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    rggen_access_state_t    state;
    logic [COUNT_WIDTH-1:0] count;
    logic                   any_active;
    logic                   any_ready;
    logic [1:0]             hit_status;
    logic [BUS_WIDTH-1:0]   hit_read_data;
    logic                   timeout;
    logic                   respond;
    rggen_status_e          resp_status;
    logic [BUS_WIDTH-1:0]   resp_read_data;

    rggen_register_response_mux #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGISTERS (REGISTERS)
    ) u_mux (
        .active        (i_reg_active),
        .ready         (i_reg_ready),
        .status        (i_reg_status),
        .read_data     (i_reg_read_data),
        .any_active    (any_active),
        .any_ready     (any_ready),
        .hit_status    (hit_status),
        .hit_read_data (hit_read_data)
    );

    assign o_host_ready      = state == STATE_IDLE;
    assign o_reg_valid       = state == STATE_ACCESS;
    assign o_host_resp_valid = state == STATE_RESPONSE;
    assign timeout           = (TIMEOUT_CYCLES != 0) && (count == COUNT_LAST);

    // Priority: decode error, then register ready, then timeout.
    always_comb begin
        respond        = !any_active || any_ready || timeout;
        resp_status    = !any_active ? RGGEN_DECODE_ERROR : any_ready ? rggen_status_e'(hit_status) : RGGEN_SLAVE_ERROR;
        resp_read_data = (any_active && any_ready && !o_reg_write) ? hit_read_data : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= STATE_IDLE;
            count            <= '0;
            o_reg_write      <= 1'b0;
            o_reg_address    <= '0;
            o_reg_write_data <= '0;
            o_reg_strobe     <= '0;
            o_host_status    <= RGGEN_OKAY;
            o_host_read_data <= '0;
        end else begin
            if (state == STATE_IDLE && i_host_valid) begin
                state            <= STATE_ACCESS;
                count            <= '0;
                o_reg_write      <= i_host_write;
                o_reg_address    <= i_host_address;
                o_reg_write_data <= i_host_write_data;
                o_reg_strobe     <= i_host_strobe;
            end
            if (state == STATE_ACCESS) begin
                if (respond) begin
                    state            <= STATE_RESPONSE;
                    o_host_status    <= resp_status;
                    o_host_read_data <= resp_read_data;
                end else if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
            if (state == STATE_RESPONSE && i_host_resp_ready) begin
                state <= STATE_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// tb_rggen_register_access_initiator: randomized commands against an offset-based response model.
module tb_rggen_register_access_initiator;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int NR = 4;
    localparam int TO = 4;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          tgt;
        int          lat;
        logic [1:0]  st;
        logic [31:0] rdata;
        int          bp;
    } trans_t;

    logic            clk = 1'b0;
    logic            i_rst;
    logic            i_host_valid;
    logic            o_host_ready;
    logic            i_host_write;
    logic [AW-1:0]   i_host_address;
    logic [BW-1:0]   i_host_write_data;
    logic [BW/8-1:0] i_host_strobe;
    logic            o_host_resp_valid;
    logic            i_host_resp_ready;
    logic [1:0]      o_host_status;
    logic [BW-1:0]   o_host_read_data;
    logic            o_reg_valid;
    logic            o_reg_write;
    logic [AW-1:0]   o_reg_address;
    logic [BW-1:0]   o_reg_write_data;
    logic [BW/8-1:0] o_reg_strobe;
    logic [NR-1:0]   i_reg_active;
    logic [NR-1:0]   i_reg_ready;
    logic [2*NR-1:0] i_reg_status;
    logic [BW*NR-1:0] i_reg_read_data;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     a_cyc = 0;
    int     mode = 0;
    trans_t cur;
    int     resp_d;
    int     rv_cnt;
    logic [1:0]  resp_st;
    logic [31:0] resp_dat;
    logic [7:0]  cap_addr;
    logic [3:0]  cap_strb;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .REGISTERS      (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_host_valid      (i_host_valid),
        .o_host_ready      (o_host_ready),
        .i_host_write      (i_host_write),
        .i_host_address    (i_host_address),
        .i_host_write_data (i_host_write_data),
        .i_host_strobe     (i_host_strobe),
        .o_host_resp_valid (o_host_resp_valid),
        .i_host_resp_ready (i_host_resp_ready),
        .o_host_status     (o_host_status),
        .o_host_read_data  (o_host_read_data),
        .o_reg_valid       (o_reg_valid),
        .o_reg_write       (o_reg_write),
        .o_reg_address     (o_reg_address),
        .o_reg_write_data  (o_reg_write_data),
        .o_reg_strobe      (o_reg_strobe),
        .i_reg_active      (i_reg_active),
        .i_reg_ready       (i_reg_ready),
        .i_reg_status      (i_reg_status),
        .i_reg_read_data   (i_reg_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response offset from the cycle the command is presented: decode error answers after the
    // first ACCESS cycle, ready k cycles into ACCESS answers at k+2, otherwise timeout at TO+1.
    function automatic int resp_off(trans_t t);
        return t.tgt < 0 ? 2 : (t.lat < TO ? t.lat + 2 : TO + 1);
    endfunction

    function automatic logic [1:0] exp_st(trans_t t);
        return t.tgt < 0 ? 2'd3 : (t.lat < TO ? t.st : 2'd2);
    endfunction

    function automatic logic [31:0] exp_data(trans_t t);
        return (t.tgt >= 0 && t.lat < TO && !t.wr) ? t.rdata : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mode == 1) begin
            int d, r;
            d = cyc - a_cyc;
            r = resp_off(cur);
            if (d == 0) begin
                rv_cnt = 0;
                resp_d = -1;
            end
            if (o_reg_valid) rv_cnt++;
            if (o_host_resp_valid && resp_d < 0) begin
                resp_d   = d;
                resp_st  = o_host_status;
                resp_dat = o_host_read_data;
            end
            if (o_reg_valid) begin
                cap_addr = o_reg_address;
                cap_strb = o_reg_strobe;
            end
            chk("host_ready", 64'(o_host_ready), 64'(d == 0 || d > r + cur.bp));
            chk("reg_valid", 64'(o_reg_valid), 64'(d >= 1 && d < r));
            chk("resp_valid", 64'(o_host_resp_valid), 64'(d >= r && d <= r + cur.bp));
            if (d >= 1 && d < r) begin
                chk("reg_write", 64'(o_reg_write), 64'(cur.wr));
                chk("reg_address", 64'(o_reg_address), 64'(cur.addr));
                chk("reg_write_data", 64'(o_reg_write_data), 64'(cur.wdata));
                chk("reg_strobe", 64'(o_reg_strobe), 64'(cur.strb));
            end
            if (d >= r && d <= r + cur.bp) begin
                chk("resp_status", 64'(o_host_status), 64'(exp_st(cur)));
                chk("resp_data", 64'(o_host_read_data), 64'(exp_data(cur)));
            end
        end else if (mode == 2) begin
            chk("rst_host_ready", 64'(o_host_ready), 64'd1);
            chk("rst_resp_valid", 64'(o_host_resp_valid), 64'd0);
            chk("rst_reg_valid", 64'(o_reg_valid), 64'd0);
            chk("rst_status", 64'(o_host_status), 64'd0);
            chk("rst_read_data", 64'(o_host_read_data), 64'd0);
            chk("rst_reg_fields", {o_reg_write, o_reg_address, o_reg_write_data, o_reg_strobe}, 64'd0);
        end else if (mode == 3) begin
            chk("idle_host_ready", 64'(o_host_ready), 64'd1);
            chk("idle_resp_valid", 64'(o_host_resp_valid), 64'd0);
            chk("idle_reg_valid", 64'(o_reg_valid), 64'd0);
        end
    end

    task automatic clear_reg();
        i_reg_active    = '0;
        i_reg_ready     = '0;
        i_reg_status    = '0;
        i_reg_read_data = '0;
    endtask

    // Register array behaviour: target active from the first ACCESS cycle, ready from lat cycles
    // later; other slices carry noise that must be masked.
    task automatic drive_reg(input trans_t t, input int d);
        logic [3:0] act;
        act = (t.tgt >= 0 && d >= 1) ? 4'(1 << t.tgt) : 4'b0;
        i_reg_active    = act;
        i_reg_ready     = ((d >= 1 + t.lat) ? act : 4'b0) | (4'($urandom) & ~act);
        i_reg_status    = 8'($urandom);
        i_reg_read_data = {$urandom, $urandom, $urandom, $urandom};
        if (t.tgt >= 0) begin
            i_reg_status[2*t.tgt+:2]     = t.st;
            i_reg_read_data[32*t.tgt+:32] = t.rdata;
        end
    endtask

    task automatic run(input trans_t t, input int abort_d);
        int r;
        r = resp_off(t);
        @(posedge clk);
        #1;
        cur               = t;
        a_cyc             = cyc;
        mode              = 1;
        i_host_valid      = 1'b1;
        i_host_write      = t.wr;
        i_host_address    = t.addr;
        i_host_write_data = t.wdata;
        i_host_strobe     = t.strb;
        i_host_resp_ready = 1'b0;
        drive_reg(t, 0);
        for (int d = 1; d <= r + t.bp; d++) begin
            @(posedge clk);
            #1;
            i_host_valid      = 1'b0;
            i_host_write_data = $urandom;
            i_host_address    = 8'($urandom);
            drive_reg(t, d);
            i_host_resp_ready = d >= r + t.bp;
            if (d == abort_d) begin
                i_rst = 1'b1;
                return;
            end
        end
    endtask

    task automatic gaps(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clear_reg();
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        trans_t t;
        i_rst = 1'b1;
        i_host_valid = 1'b0;
        i_host_write = 1'b0;
        i_host_address = '0;
        i_host_write_data = '0;
        i_host_strobe = '0;
        i_host_resp_ready = 1'b0;
        clear_reg();
        @(posedge clk);
        #1 mode = 2;
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(posedge clk);
        #1 mode = 3;
        gaps(2);

        t = '{wr: 1'b0, addr: 8'h08, wdata: 32'h0, strb: 4'hF, tgt: 2, lat: 2, st: 2'd0, rdata: 32'hDEADBEEF, bp: 0};
        run(t, 0);
        settle();
        chk("pin_read_latency", 64'(resp_d), 64'd4);
        chk("pin_read_data", 64'(resp_dat), 64'hDEADBEEF);
        chk("pin_read_status", 64'(resp_st), 64'd0);

        t = '{wr: 1'b1, addr: 8'h10, wdata: 32'h12345678, strb: 4'b0011, tgt: 1, lat: 0, st: 2'd0, rdata: 32'hA5A5A5A5, bp: 0};
        run(t, 0);
        settle();
        chk("pin_write_latency", 64'(resp_d), 64'd2);
        chk("pin_write_addr", 64'(cap_addr), 64'h10);
        chk("pin_write_strobe", 64'(cap_strb), 64'b0011);
        chk("pin_write_data_zero", 64'(resp_dat), 64'd0);

        t = '{wr: 1'b0, addr: 8'hF0, wdata: 32'h0, strb: 4'hF, tgt: -1, lat: 0, st: 2'd0, rdata: 32'h0, bp: 0};
        run(t, 0);
        settle();
        chk("pin_decode_latency", 64'(resp_d), 64'd2);
        chk("pin_decode_status", 64'(resp_st), 64'd3);

        t = '{wr: 1'b0, addr: 8'h00, wdata: 32'h0, strb: 4'hF, tgt: 0, lat: 99, st: 2'd0, rdata: 32'h11111111, bp: 0};
        run(t, 0);
        settle();
        chk("pin_timeout_latency", 64'(resp_d), 64'd5);
        chk("pin_timeout_status", 64'(resp_st), 64'd2);
        chk("pin_timeout_reg_valid_cycles", 64'(rv_cnt), 64'd4);

        t = '{wr: 1'b0, addr: 8'h0C, wdata: 32'h0, strb: 4'hF, tgt: 3, lat: 1, st: 2'd1, rdata: 32'hCAFEF00D, bp: 3};
        run(t, 0);
        settle();
        chk("pin_bp_latency", 64'(resp_d), 64'd3);
        chk("pin_bp_data", 64'(o_host_read_data), 64'hCAFEF00D);
        t = '{wr: 1'b0, addr: 8'hF4, wdata: 32'h0, strb: 4'hF, tgt: -1, lat: 0, st: 2'd0, rdata: 32'h0, bp: 0};
        run(t, 0);
        settle();
        chk("pin_b2b_latency", 64'(resp_d), 64'd2);

        t = '{wr: 1'b0, addr: 8'h04, wdata: 32'h0, strb: 4'hF, tgt: 1, lat: 99, st: 2'd0, rdata: 32'h22222222, bp: 0};
        run(t, 2);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        mode  = 2;
        clear_reg();
        @(posedge clk);
        #1 mode = 3;
        gaps(8);

        for (int n = 0; n < 60; n++) begin
            t.wr    = 1'($urandom);
            t.addr  = 8'($urandom);
            t.wdata = $urandom;
            t.strb  = 4'($urandom);
            t.tgt   = int'($urandom_range(0, 4)) - 1;
            t.lat   = int'($urandom_range(0, 6));
            t.st    = 2'($urandom);
            t.rdata = $urandom;
            t.bp    = int'($urandom_range(0, 3));
            run(t, 0);
            gaps(int'($urandom_range(0, 2)));
        end
        gaps(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
